// File: rtl/fetch_sequencer_pkg.sv
// Shared processor package: sequencer state encoding, C-bus select codes and
// the Moore strobe decode used by the fetch sequencer.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH_ADDR = 3'd1,
        S_FETCH_WAIT = 3'd2,
        S_FETCH_LOAD = 3'd3,
        S_EXEC       = 3'd4,
        S_HALTED     = 3'd5
    } state_e;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_PC   = 2'd1;
    localparam logic [1:0] SEL_MEM  = 2'd2;

    typedef struct packed {
        logic       pc_inc;
        logic       ar_we;
        logic       ir_we;
        logic [1:0] c_bus_sel;
        logic       mem_rd;
        logic       busy;
        logic       halted;
    } strobes_t;

    function automatic strobes_t decode_state(state_e s);
        strobes_t o;
        o = '0;
        o.c_bus_sel = SEL_NONE;
        case (s)
            S_FETCH_ADDR: begin
                o.ar_we     = 1'b1;
                o.c_bus_sel = SEL_PC;
                o.busy      = 1'b1;
            end
            S_FETCH_WAIT: begin
                o.mem_rd = 1'b1;
                o.busy   = 1'b1;
            end
            S_FETCH_LOAD: begin
                o.ir_we     = 1'b1;
                o.pc_inc    = 1'b1;
                o.c_bus_sel = SEL_MEM;
                o.busy      = 1'b1;
            end
            S_EXEC:   o.busy   = 1'b1;
            S_HALTED: o.halted = 1'b1;
            default:  o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control bus between the fetch sequencer, its datapath strobes and the
// execute unit handshake.
interface fetch_sequencer_if #(
    parameter int DATA_LEN = 16
) ();

    logic                start;
    logic                halt_req;
    logic                exec_done;
    logic                pc_inc;
    logic                ar_we;
    logic                ir_we;
    logic [1:0]          c_bus_sel;
    logic                mem_rd;
    logic                exec_start;
    logic                busy;
    logic                halted;
    logic [DATA_LEN-1:0] instr_count;

    modport master (
        input  start, halt_req, exec_done,
        output pc_inc, ar_we, ir_we, c_bus_sel, mem_rd, exec_start,
               busy, halted, instr_count
    );

    modport slave (
        output start, halt_req, exec_done,
        input  pc_inc, ar_we, ir_we, c_bus_sel, mem_rd, exec_start,
               busy, halted, instr_count
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks address/wait/load/execute phases and
// emits registered Moore strobes for the datapath and execute unit.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int DATA_LEN = 16,
    parameter int MEM_WAIT = 2
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_e              state_q, state_d;
    logic [3:0]          wait_q, wait_d;
    logic                halt_pend_q, halt_pend_d;
    logic [DATA_LEN-1:0] count_q, count_d;
    strobes_t            out_q;
    logic                exec_start_q;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        halt_pend_d = halt_pend_q;
        count_d     = count_q;

        if (bus.halt_req && (state_q != S_IDLE) && (state_q != S_HALTED)) begin
            halt_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH_ADDR;
            end
            S_FETCH_ADDR: begin
                wait_d  = WAIT_LOAD;
                state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                if (wait_q == '0) state_d = S_FETCH_LOAD;
                else              wait_d  = wait_q - 4'd1;
            end
            S_FETCH_LOAD: begin
                count_d = count_q + DATA_LEN'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // A halt request arriving with exec_done still stops this instruction.
                if (bus.exec_done) begin
                    state_d = (halt_pend_q || bus.halt_req) ? S_HALTED : S_FETCH_ADDR;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            halt_pend_q  <= 1'b0;
            count_q      <= '0;
            out_q        <= '0;
            exec_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            halt_pend_q  <= halt_pend_d;
            count_q      <= count_d;
            out_q        <= decode_state(state_d);
            exec_start_q <= (state_q == S_FETCH_LOAD);
        end
    end

    assign bus.pc_inc      = out_q.pc_inc;
    assign bus.ar_we       = out_q.ar_we;
    assign bus.ir_we       = out_q.ir_we;
    assign bus.c_bus_sel   = out_q.c_bus_sel;
    assign bus.mem_rd      = out_q.mem_rd;
    assign bus.exec_start  = exec_start_q;
    assign bus.busy        = out_q.busy;
    assign bus.halted      = out_q.halted;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table on the default
// configuration plus hand sequences for counter wrap and single-cycle wait.
module tb_fetch_sequencer;

    typedef enum int { P_IDLE, P_FA, P_FW, P_FL, P_EX1, P_EX, P_HALT } phase_e;

    typedef struct {
        bit          r;
        bit          s;
        bit          h;
        bit          d;
        phase_e      ph;
        int unsigned cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;

    fetch_sequencer_if #(.DATA_LEN(16)) if0 ();
    fetch_sequencer_if #(.DATA_LEN(4))  if1 ();
    fetch_sequencer_if #(.DATA_LEN(16)) if2 ();

    fetch_sequencer #(.DATA_LEN(16), .MEM_WAIT(2)) dut0 (.clk(clk), .reset(rst0), .bus(if0));
    fetch_sequencer #(.DATA_LEN(4),  .MEM_WAIT(2)) dut1 (.clk(clk), .reset(rst1), .bus(if1));
    fetch_sequencer #(.DATA_LEN(16), .MEM_WAIT(1)) dut2 (.clk(clk), .reset(rst2), .bus(if2));

    // {pc_inc, ar_we, ir_we, c_bus_sel[1:0], mem_rd, exec_start, busy, halted}
    logic [8:0] s0, s2;
    assign s0 = {if0.pc_inc, if0.ar_we, if0.ir_we, if0.c_bus_sel, if0.mem_rd,
                 if0.exec_start, if0.busy, if0.halted};
    assign s2 = {if2.pc_inc, if2.ar_we, if2.ir_we, if2.c_bus_sel, if2.mem_rd,
                 if2.exec_start, if2.busy, if2.halted};

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[$];

    function automatic logic [8:0] expect_of(phase_e p);
        case (p)
            P_FA:    return 9'b0_1_0_01_0_0_1_0;
            P_FW:    return 9'b0_0_0_00_1_0_1_0;
            P_FL:    return 9'b1_0_1_10_0_0_1_0;
            P_EX1:   return 9'b0_0_0_00_0_1_1_0;
            P_EX:    return 9'b0_0_0_00_0_0_1_0;
            P_HALT:  return 9'b0_0_0_00_0_0_0_1;
            default: return 9'b0;
        endcase
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
    endtask

    task automatic add(input bit r, input bit s, input bit h, input bit d,
                       input phase_e ph, input int unsigned cnt);
        vec_t v;
        v.r = r; v.s = s; v.h = h; v.d = d; v.ph = ph; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pc_pulses;
        int w;

        if0.start = 0; if0.halt_req = 0; if0.exec_done = 0;
        if1.start = 0; if1.halt_req = 0; if1.exec_done = 0;
        if2.start = 0; if2.halt_req = 0; if2.exec_done = 0;

        //  r  s  h  d  phase   count   (row inputs are sampled at the edge producing the row's state)
        add(1, 0, 0, 0, P_IDLE, 0);   // 0  reset
        add(0, 1, 0, 0, P_FA,   0);   // 1  start -> ar_we cycle 1
        add(0, 0, 0, 0, P_FW,   0);   // 2
        add(0, 0, 0, 0, P_FW,   0);   // 3
        add(0, 0, 0, 1, P_FL,   0);   // 4  exec_done outside EXEC ignored
        add(0, 0, 0, 1, P_EX1,  1);   // 5
        add(0, 1, 0, 0, P_EX,   1);   // 6  start while busy ignored
        add(0, 0, 0, 0, P_EX,   1);   // 7
        add(0, 0, 0, 1, P_FA,   1);   // 8
        add(0, 0, 0, 0, P_FW,   1);   // 9
        add(0, 0, 0, 0, P_FW,   1);   // 10
        add(0, 0, 0, 0, P_FL,   1);   // 11
        add(0, 0, 0, 0, P_EX1,  2);   // 12
        add(0, 0, 0, 1, P_FA,   2);   // 13 done in first EXEC cycle: 5-cycle fetch spacing
        add(0, 0, 0, 0, P_FW,   2);   // 14
        add(0, 0, 1, 0, P_FW,   2);   // 15 halt_req sampled in FETCH_WAIT
        add(0, 0, 0, 0, P_FL,   2);   // 16
        add(0, 0, 0, 0, P_EX1,  3);   // 17
        add(0, 0, 0, 0, P_EX,   3);   // 18
        add(0, 0, 0, 1, P_HALT, 3);   // 19
        add(0, 1, 0, 0, P_HALT, 3);   // 20 start ignored in HALTED
        add(0, 1, 0, 1, P_HALT, 3);   // 21
        add(1, 0, 0, 0, P_IDLE, 0);   // 22
        add(0, 0, 1, 0, P_IDLE, 0);   // 23 halt_req in IDLE ignored
        add(0, 1, 0, 0, P_FA,   0);   // 24
        add(0, 0, 0, 0, P_FW,   0);   // 25
        add(0, 0, 0, 0, P_FW,   0);   // 26
        add(0, 0, 0, 0, P_FL,   0);   // 27
        add(0, 0, 0, 0, P_EX1,  1);   // 28
        add(0, 0, 0, 1, P_FA,   1);   // 29 no stale halt from IDLE
        add(0, 0, 0, 0, P_FW,   1);   // 30
        add(1, 1, 1, 1, P_IDLE, 0);   // 31 reset mid-fetch wins over everything
        add(0, 0, 0, 0, P_IDLE, 0);   // 32
        add(0, 1, 0, 0, P_FA,   0);   // 33
        add(0, 0, 0, 0, P_FW,   0);   // 34
        add(0, 0, 0, 0, P_FW,   0);   // 35
        add(0, 0, 0, 0, P_FL,   0);   // 36
        add(0, 0, 0, 0, P_EX1,  1);   // 37
        add(0, 0, 0, 1, P_FA,   1);   // 38 halt_pending cleared by reset

        pc_pulses = 0;
        foreach (vecs[i]) begin
            rst0          = vecs[i].r;
            if0.start     = vecs[i].s;
            if0.halt_req  = vecs[i].h;
            if0.exec_done = vecs[i].d;
            step();
            check("strobes", i, {23'b0, s0}, {23'b0, expect_of(vecs[i].ph)});
            check("instr_count", i, 32'(if0.instr_count), 32'(vecs[i].cnt));
            check("we_exclusive", i,
                  {31'b0, (if0.ar_we & if0.pc_inc) | (if0.ar_we & if0.ir_we)}, 32'd0);
            if (i >= 1 && i <= 21) pc_pulses += int'(if0.pc_inc);
            if (i == 21) check("pc_inc_pulses", i, 32'(pc_pulses), 32'd3);
        end
        rst0 = 1'b1;

        // 4-bit counter wraps across 17 back-to-back fetches.
        step();
        check("wrap_reset_count", 0, 32'(if1.instr_count), 32'd0);
        rst1 = 1'b0;
        if1.start = 1'b1;
        if1.exec_done = 1'b1;
        for (int k = 0; k < 17; k++) begin
            w = 0;
            step();
            while (!if1.exec_start && w < 20) begin
                step();
                w++;
            end
            check("wait_exec_start", k, 32'(if1.exec_start), 32'd1);
            if (!if1.exec_start) break;
            check("wrap_count", k, 32'(if1.instr_count), 32'((k + 1) % 16));
        end
        rst1 = 1'b1;

        // Single-cycle memory wait, then exec_done with halt_req in first EXEC cycle.
        step();
        check("mw1_reset", 0, {23'b0, s2}, {23'b0, expect_of(P_IDLE)});
        rst2 = 1'b0; if2.start = 1'b1;
        step();
        check("mw1_fa", 0, {23'b0, s2}, {23'b0, expect_of(P_FA)});
        if2.start = 1'b0;
        step();
        check("mw1_fw", 0, {23'b0, s2}, {23'b0, expect_of(P_FW)});
        step();
        check("mw1_fl", 0, {23'b0, s2}, {23'b0, expect_of(P_FL)});
        step();
        check("mw1_ex1", 0, {23'b0, s2}, {23'b0, expect_of(P_EX1)});
        check("mw1_count", 0, 32'(if2.instr_count), 32'd1);
        if2.exec_done = 1'b1; if2.halt_req = 1'b1;
        step();
        check("mw1_halt", 0, {23'b0, s2}, {23'b0, expect_of(P_HALT)});
        if2.exec_done = 1'b0; if2.halt_req = 1'b0; if2.start = 1'b1;
        step();
        check("mw1_halt_hold", 0, {23'b0, s2}, {23'b0, expect_of(P_HALT)});
        check("mw1_count_hold", 0, 32'(if2.instr_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001: Parameter DATA_LEN, default 16: width of instr_count.
REQ-002: Parameter MEM_WAIT, default 2: number of memory-read cycles; legal range 1..15.
REQ-003: clk  input  1  single clock; all state updates on posedge clk.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: start  input  1  level; begins fetching when sampled in IDLE.
REQ-006: halt_req  input  1  single-cycle or level request to stop after the current instruction.
REQ-007: exec_done  input  1  execute unit finished the current instruction.
REQ-008: pc_inc  output  1  increment strobe to the program counter register.
REQ-009: ar_we  output  1  write enable to the address register.
REQ-010: ir_we  output  1  write enable to the instruction register.
REQ-011: c_bus_sel  output  2  C-bus source: 0 = none, 1 = PC, 2 = MEM.
REQ-012: mem_rd  output  1  memory read strobe.
REQ-013: exec_start  output  1  one-cycle pulse starting the execute unit.
REQ-014: busy  output  1  high in every state except IDLE and HALTED.
REQ-015: halted  output  1  high in HALTED.
REQ-016: instr_count  output  DATA_LEN  count of instructions fetched.

Function
REQ-017: The FSM SHALL have states IDLE, FETCH_ADDR, FETCH_WAIT, FETCH_LOAD, EXEC and HALTED.
REQ-018: All strobes SHALL be Moore outputs decoded from the registered state only.
REQ-019: In IDLE, start=1 SHALL move the FSM to FETCH_ADDR; otherwise it stays in IDLE.
REQ-020: In FETCH_ADDR, for exactly 1 cycle, ar_we=1 and c_bus_sel=1; the wait counter loads MEM_WAIT-1; next state is FETCH_WAIT.
REQ-021: In FETCH_WAIT, mem_rd=1; the counter decrements each cycle; the FSM leaves for FETCH_LOAD in the cycle the counter is 0, so FETCH_WAIT lasts exactly MEM_WAIT cycles.
REQ-022: In FETCH_LOAD, for exactly 1 cycle, ir_we=1, c_bus_sel=2 and pc_inc=1; instr_count increments; next state is EXEC.
REQ-023: instr_count SHALL wrap from all-ones to 0.
REQ-024: exec_start SHALL be 1 only in the first EXEC cycle.
REQ-025: EXEC SHALL hold until exec_done=1; exec_done SHALL be honoured in the first EXEC cycle as well.
REQ-026: On exec_done, the FSM SHALL go to HALTED if halt_pending or halt_req is 1, else to FETCH_ADDR.
REQ-027: halt_pending SHALL set on halt_req=1 in any state except IDLE and HALTED, and clear only on reset.
REQ-028: halt_req sampled in IDLE SHALL be ignored.
REQ-029: HALTED SHALL be terminal until reset; start is ignored in HALTED.
REQ-030: start while busy, and exec_done outside EXEC, SHALL be ignored.
REQ-031: pc_inc and ar_we SHALL never both be 1 in the same cycle.
REQ-032: At most one of ar_we and ir_we SHALL be 1 in any cycle.
REQ-033: Fetch-to-fetch latency with exec_done in the first EXEC cycle SHALL be MEM_WAIT+3 cycles.

Reset
REQ-034: reset=1 at a clock edge SHALL force IDLE, clear the wait counter, halt_pending and instr_count, and drive all strobes, busy and halted to 0, from any state including mid-fetch.
REQ-035: reset SHALL have priority over start, halt_req and exec_done in the same cycle.
REQ-036: This block SHALL NOT drive the reset of the datapath registers.

Structure
REQ-037: The state encoding (3-bit) and the C-bus select constants (SEL_NONE, SEL_PC, SEL_MEM) SHALL live in the shared processor package.
REQ-038: The block SHALL be one module with no sub-modules; the wait counter is 4 bits inline.

Verification
REQ-039: Reset then start=1 with MEM_WAIT=2 -> ar_we in cycle 1, mem_rd in cycles 2-3, ir_we/pc_inc/c_bus_sel=2 in cycle 4, exec_start in cycle 5, instr_count=1.
REQ-040: exec_done held for 3 EXEC cycles, then 3 instructions run -> instr_count=3, exactly 3 pc_inc pulses, no strobe in EXEC.
REQ-041: halt_req pulsed during FETCH_WAIT -> instruction completes, then HALTED, halted=1, busy=0; start=1 afterwards -> state unchanged.
REQ-042: reset asserted in FETCH_WAIT -> next cycle IDLE, mem_rd=0, instr_count=0.
REQ-043: DATA_LEN=4, 17 fetches -> instr_count wraps 15->0 and reads 1.
REQ-044: MEM_WAIT=1 -> FETCH_WAIT lasts one cycle; exec_done together with halt_req in the first EXEC cycle -> HALTED.
